// File: rtl/lights_out_grid_engine.sv
`default_nettype none
// ============================================================================
//  Module      : lights_out_grid_engine
//  Description : Lights-Out puzzle engine. Accepts PRESS / SCRAMBLE / CLEAR
//                commands, keeps the lit-cell board, counts player moves and
//                flags solved / win / error conditions. SCRAMBLE applies a
//                fixed number of LFSR-chosen presses, one per enabled cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module lights_out_grid_engine #(
  parameter int ROWS       = 5,
  parameter int COLS       = 5,
  parameter int WRAP       = 0,
  parameter int SCRAMBLE_N = 16,
  parameter int CNT_W      = 10
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [3:0]             cmd_row,
  input  logic [3:0]             cmd_col,
  input  logic [15:0]            cmd_seed,
  output logic [ROWS*COLS-1:0]   board,
  output logic [CNT_W-1:0]       move_count,
  output logic                   busy,
  output logic                   solved,
  output logic                   win_pulse,
  output logic                   err_pulse
);

  localparam int          C_CELLS     = ROWS * COLS;
  localparam logic [0:0]  ST_IDLE     = 1'b0;
  localparam logic [0:0]  ST_SCRAMBLE = 1'b1;
  localparam logic [15:0] C_SEED_ZERO = 16'hACE1;
  localparam logic [1:0]  C_OP_PRESS  = 2'b00;
  localparam logic [1:0]  C_OP_SCRAM  = 2'b01;
  localparam logic [1:0]  C_OP_CLEAR  = 2'b10;

  // Toggle mask for a press at (r,c). Toggles are XOR-combined so that, on a
  // torus narrower than 3 cells, neighbours landing on the same cell cancel.
  function automatic logic [C_CELLS-1:0] press_mask(input int r, input int c);
    logic [C_CELLS-1:0] m;
    int up, dn, lf, rt;
    m = '0;
    m[r*COLS+c] = 1'b1;
    if (WRAP != 0) begin
      up = (r == 0)      ? ROWS-1 : r-1;
      dn = (r == ROWS-1) ? 0      : r+1;
      lf = (c == 0)      ? COLS-1 : c-1;
      rt = (c == COLS-1) ? 0      : c+1;
      m[up*COLS+c] ^= 1'b1;
      m[dn*COLS+c] ^= 1'b1;
      m[r*COLS+lf] ^= 1'b1;
      m[r*COLS+rt] ^= 1'b1;
    end else begin
      if (r > 0)      m[(r-1)*COLS+c] = 1'b1;
      if (r < ROWS-1) m[(r+1)*COLS+c] = 1'b1;
      if (c > 0)      m[r*COLS+c-1]   = 1'b1;
      if (c < COLS-1) m[r*COLS+c+1]   = 1'b1;
    end
    return m;
  endfunction

  logic [0:0]         r_state_q,  w_state_d;
  logic [C_CELLS-1:0] r_board_q,  w_board_d;
  logic [CNT_W-1:0]   r_cnt_q,    w_cnt_d;
  logic               r_armed_q,  w_armed_d;
  logic [15:0]        r_lfsr_q,   w_lfsr_d;
  logic [7:0]         r_step_q,   w_step_d;
  logic               r_win_q,    w_win_d;
  logic               r_err_q,    w_err_d;

  logic               w_accept;
  logic               w_legal;
  int                 w_row;
  int                 w_col;
  logic [C_CELLS-1:0] w_mask;
  logic [C_CELLS-1:0] w_pressed;
  logic [15:0]        w_lfsr_step;

  assign cmd_ready   = ena && (r_state_q == ST_IDLE);
  assign w_accept    = cmd_valid && cmd_ready;
  assign w_legal     = (int'(cmd_row) < ROWS) && (int'(cmd_col) < COLS);
  assign w_lfsr_step = {r_lfsr_q[14:0],
                        r_lfsr_q[15] ^ r_lfsr_q[13] ^ r_lfsr_q[12] ^ r_lfsr_q[10]};

  // One shared mask generator: scramble uses the pre-step LFSR, otherwise the
  // command coordinates (forced to a safe cell when out of range).
  always_comb begin
    w_row = 0;
    w_col = 0;
    if (r_state_q == ST_SCRAMBLE) begin
      w_row = int'(r_lfsr_q[7:0])  % ROWS;
      w_col = int'(r_lfsr_q[15:8]) % COLS;
    end else if (w_legal) begin
      w_row = int'(cmd_row);
      w_col = int'(cmd_col);
    end
    w_mask    = press_mask(w_row, w_col);
    w_pressed = r_board_q ^ w_mask;
  end

  // Next-state decode for command acceptance and scramble stepping.
  always_comb begin
    w_state_d = r_state_q;
    w_board_d = r_board_q;
    w_cnt_d   = r_cnt_q;
    w_armed_d = r_armed_q;
    w_lfsr_d  = r_lfsr_q;
    w_step_d  = r_step_q;
    w_win_d   = 1'b0;
    w_err_d   = 1'b0;
    if (r_state_q == ST_SCRAMBLE) begin
      w_board_d = w_pressed;
      w_lfsr_d  = w_lfsr_step;
      w_step_d  = r_step_q + 8'd1;
      if (r_step_q == 8'(SCRAMBLE_N - 1)) begin
        w_state_d = ST_IDLE;
        w_armed_d = 1'b1;
      end
    end else if (w_accept) begin
      case (cmd_op)
        C_OP_PRESS: begin
          if (w_legal) begin
            w_board_d = w_pressed;
            w_cnt_d   = (r_cnt_q == '1) ? r_cnt_q : r_cnt_q + 1'b1;
            w_win_d   = r_armed_q && (w_pressed == '0);
          end else begin
            w_err_d = 1'b1;
          end
        end
        C_OP_SCRAM: begin
          w_board_d = '0;
          w_cnt_d   = '0;
          w_armed_d = 1'b0;
          w_lfsr_d  = (cmd_seed == 16'h0000) ? C_SEED_ZERO : cmd_seed;
          w_step_d  = 8'd0;
          w_state_d = ST_SCRAMBLE;
        end
        C_OP_CLEAR: begin
          w_board_d = '0;
          w_cnt_d   = '0;
          w_armed_d = 1'b0;
        end
        default: w_err_d = 1'b1;
      endcase
    end
  end

  // State registers; ena low holds everything except the one-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= ST_IDLE;
      r_board_q <= '0;
      r_cnt_q   <= '0;
      r_armed_q <= 1'b0;
      r_lfsr_q  <= C_SEED_ZERO;
      r_step_q  <= 8'd0;
      r_win_q   <= 1'b0;
      r_err_q   <= 1'b0;
    end else if (ena) begin
      r_state_q <= w_state_d;
      r_board_q <= w_board_d;
      r_cnt_q   <= w_cnt_d;
      r_armed_q <= w_armed_d;
      r_lfsr_q  <= w_lfsr_d;
      r_step_q  <= w_step_d;
      r_win_q   <= w_win_d;
      r_err_q   <= w_err_d;
    end else begin
      r_win_q <= 1'b0;
      r_err_q <= 1'b0;
    end
  end

  assign board      = r_board_q;
  assign move_count = r_cnt_q;
  assign busy       = (r_state_q == ST_SCRAMBLE);
  assign solved     = r_armed_q && (r_state_q == ST_IDLE) && (r_board_q == '0);
  assign win_pulse  = r_win_q && ena;
  assign err_pulse  = r_err_q && ena;

endmodule
`default_nettype wire

// File: tb/tb_lights_out_grid_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lights_out_grid_engine
//  Description : Self-checking bench. Two engines (flat 5x5 / 10-bit counter
//                and toroidal 5x5 / 4-bit counter) share one command stream
//                and are compared against a cell-distance board model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lights_out_grid_engine;

  localparam int NR = 5;
  localparam int NC = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic [3:0]  cmd_row = 4'd0;
  logic [3:0]  cmd_col = 4'd0;
  logic [15:0] cmd_seed = 16'd0;

  logic        a_ready, a_busy, a_solved, a_win, a_err;
  logic [24:0] a_board;
  logic [9:0]  a_cnt;
  logic        b_ready, b_busy, b_solved, b_win, b_err;
  logic [24:0] b_board;
  logic [3:0]  b_cnt;

  lights_out_grid_engine #(.ROWS(NR), .COLS(NC), .WRAP(0), .SCRAMBLE_N(16), .CNT_W(10)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_seed(cmd_seed),
    .board(a_board), .move_count(a_cnt), .busy(a_busy), .solved(a_solved),
    .win_pulse(a_win), .err_pulse(a_err));

  lights_out_grid_engine #(.ROWS(NR), .COLS(NC), .WRAP(1), .SCRAMBLE_N(16), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ena(ena), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
    .cmd_op(cmd_op), .cmd_row(cmd_row), .cmd_col(cmd_col), .cmd_seed(cmd_seed),
    .board(b_board), .move_count(b_cnt), .busy(b_busy), .solved(b_solved),
    .win_pulse(b_win), .err_pulse(b_err));

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [24:0] mb_a, mb_b;
  int          mc_a, mc_b;
  bit          m_armed;
  int          log_r[$];
  int          log_c[$];
  int          wins_a, wins_b, exp_wins_a, exp_wins_b;

  // A press toggles every cell at (toroidal) Manhattan distance <= 1.
  function automatic logic [24:0] mmask(int r, int c, bit wrap);
    logic [24:0] m;
    int dr, dc;
    m = '0;
    for (int i = 0; i < NR; i++) begin
      for (int j = 0; j < NC; j++) begin
        dr = (i > r) ? i - r : r - i;
        dc = (j > c) ? j - c : c - j;
        if (wrap) begin
          if (NR - dr < dr) dr = NR - dr;
          if (NC - dc < dc) dc = NC - dc;
        end
        if (dr + dc <= 1) m[i*NC+j] = 1'b1;
      end
    end
    return m;
  endfunction

  function automatic logic [15:0] lfsr_next(logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(string tag);
    chk({tag, "_board_a"}, 32'(a_board), 32'(mb_a));
    chk({tag, "_board_b"}, 32'(b_board), 32'(mb_b));
    chk({tag, "_cnt_a"}, 32'(a_cnt), 32'(mc_a));
    chk({tag, "_cnt_b"}, 32'(b_cnt), 32'(mc_b));
    chk({tag, "_solved_a"}, 32'(a_solved), 32'(m_armed && mb_a == 0));
    chk({tag, "_solved_b"}, 32'(b_solved), 32'(m_armed && mb_b == 0));
  endtask

  // Offer one command; returns with the bench #1 after the accepting edge.
  task automatic send(logic [1:0] op, int r, int c, logic [15:0] seed);
    int k;
    k = 0;
    while (!a_ready && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) chk("ready_timeout", 32'(a_ready), 32'd1);
    cmd_op = op; cmd_row = 4'(r); cmd_col = 4'(c); cmd_seed = seed;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic do_press(int r, int c);
    bit legal, wa, wb;
    logic [24:0] na, nb;
    legal = (r < NR) && (c < NC);
    wa = 0; wb = 0;
    send(2'b00, r, c, 16'h0);
    if (legal) begin
      na = mb_a ^ mmask(r, c, 1'b0);
      nb = mb_b ^ mmask(r, c, 1'b1);
      wa = m_armed && (na == 0);
      wb = m_armed && (nb == 0);
      mb_a = na; mb_b = nb;
      mc_a = (mc_a < 1023) ? mc_a + 1 : 1023;
      mc_b = (mc_b < 15) ? mc_b + 1 : 15;
    end
    exp_wins_a += int'(wa); exp_wins_b += int'(wb);
    wins_a += int'(a_win); wins_b += int'(b_win);
    chk("press_err_a", 32'(a_err), 32'(!legal));
    chk("press_err_b", 32'(b_err), 32'(!legal));
    chk("press_win_a", 32'(a_win), 32'(wa));
    chk("press_win_b", 32'(b_win), 32'(wb));
    check_state("press");
  endtask

  task automatic do_clear();
    send(2'b10, 0, 0, 16'h0);
    mb_a = 0; mb_b = 0; mc_a = 0; mc_b = 0; m_armed = 0;
    check_state("clear");
  endtask

  // Model the full scramble, then accept it; optionally pause via ena.
  task automatic do_scramble(logic [15:0] seed, bit glitch);
    logic [15:0] l;
    int r, c, n;
    l = (seed == 16'h0) ? 16'hACE1 : seed;
    log_r.delete(); log_c.delete();
    mb_a = 0; mb_b = 0; mc_a = 0; mc_b = 0;
    for (int i = 0; i < 16; i++) begin
      r = int'(l[7:0]) % NR;
      c = int'(l[15:8]) % NC;
      log_r.push_back(r); log_c.push_back(c);
      mb_a ^= mmask(r, c, 1'b0);
      mb_b ^= mmask(r, c, 1'b1);
      l = lfsr_next(l);
    end
    m_armed = 1;
    send(2'b01, 0, 0, seed);
    n = 0;
    while (a_busy && n < 100) begin
      n++;
      chk("scr_ready_low", 32'(a_ready), 32'd0);
      if (glitch && n == 5) ena = 1'b0;
      if (glitch && n == 8) ena = 1'b1;
      @(posedge clk); #1;
    end
    chk("scr_busy_cycles", 32'(n), glitch ? 32'd19 : 32'd16);
    chk("scr_busy_b", 32'(b_busy), 32'd0);
    check_state("scramble");
  endtask

  task automatic replay();
    exp_wins_a = 0; exp_wins_b = 0; wins_a = 0; wins_b = 0;
    for (int i = 0; i < log_r.size(); i++) do_press(log_r[i], log_c[i]);
    chk("replay_solved_a", 32'(a_solved), 32'd1);
    chk("replay_solved_b", 32'(b_solved), 32'd1);
    chk("replay_wins_a", 32'(wins_a), 32'(exp_wins_a));
    chk("replay_wins_b", 32'(wins_b), 32'(exp_wins_b));
    chk("replay_cnt_a", 32'(a_cnt), 32'd16);
    chk("replay_cnt_b", 32'(b_cnt), 32'd15);
  endtask

  initial begin
    logic [24:0] hold_a;
    mb_a = 0; mb_b = 0; mc_a = 0; mc_b = 0; m_armed = 0;
    exp_wins_a = 0; exp_wins_b = 0; wins_a = 0; wins_b = 0;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(a_ready), 32'd1);
    chk("rst_busy", 32'(a_busy), 32'd0);
    check_state("reset");

    // Centre press and undo
    do_press(2, 2);
    chk("p22_bits", 32'(a_board), 32'h0002_3880);
    chk("p22_cnt", 32'(a_cnt), 32'd1);
    do_press(2, 2);
    chk("p22_twice", 32'(a_board), 32'd0);
    chk("p22_cnt2", 32'(a_cnt), 32'd2);

    // Corner press, flat vs torus; out-of-range and reserved op
    do_clear();
    do_press(0, 0);
    chk("p00_flat", 32'(a_board), 32'h0000_0023);
    chk("p00_wrap", 32'(b_board), 32'h0010_0033);
    do_press(5, 0);
    do_press(0, 7);
    send(2'b11, 1, 1, 16'h0);
    chk("rsv_err", 32'(a_err), 32'd1);
    check_state("reserved");

    // Counter saturation with 20 legal presses
    do_clear();
    for (int i = 0; i < 20; i++) do_press($urandom_range(0, NR-1), $urandom_range(0, NC-1));
    chk("sat_cnt_a", 32'(a_cnt), 32'd20);
    chk("sat_cnt_b", 32'(b_cnt), 32'd15);

    // Random presses including illegal coordinates
    for (int i = 0; i < 30; i++) do_press($urandom_range(0, 6), $urandom_range(0, 6));

    // Scramble seed 1, replay to solve
    do_scramble(16'h0001, 1'b0);
    replay();
    do_press(1, 3);

    // Scramble paused by ena
    do_scramble(16'h0001, 1'b1);
    replay();

    // Reset during scramble cycle 5
    send(2'b01, 0, 0, 16'h0001);
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_busy_before", 32'(a_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    mb_a = 0; mb_b = 0; mc_a = 0; mc_b = 0; m_armed = 0;
    chk("mid_busy", 32'(a_busy), 32'd0);
    check_state("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_rst_ready", 32'(a_ready), 32'd1);
    do_scramble(16'h0001, 1'b0);
    replay();

    // Zero seed and random seeds, with random play afterwards
    do_scramble(16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_scramble(16'($urandom), 1'b0);
      for (int i = 0; i < 10; i++) do_press($urandom_range(0, 5), $urandom_range(0, 5));
    end

    // ena low in IDLE: nothing accepted, nothing changes
    hold_a = a_board;
    ena = 1'b0;
    cmd_op = 2'b10; cmd_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("ena_ready", 32'(a_ready), 32'd0);
    chk("ena_hold", 32'(a_board), 32'(hold_a));
    cmd_valid = 1'b0;
    ena = 1'b1;
    check_state("ena_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
